sw_debounce_sync: RTL
=====================

Name: sw_debounce_sync

Overview:
Conditions raw board slide switches before they reach the switch-input PIO's in_port.
- Synchronises each asynchronous switch bit into the clk domain.
- Rejects contact bounce with a per-bit stability counter.
- Presents clean, glitch-free levels on sw_clean; sw_clean[3:0] drives the PIO in_port directly.

Parameters:
WIDTH, 4, number of switch bits (matches PIO in_port width)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2)
CNT_MAX, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz; >=2)
CNT_W, 19, counter width; must satisfy 2**CNT_W >= CNT_MAX

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sw_raw  input  WIDTH  raw switch pins, asynchronous, bouncing
sw_clean  output  WIDTH  debounced level per bit; feeds PIO in_port
sw_changed  output  1  one-cycle pulse when any sw_clean bit updated this cycle

Behaviour:
Clock and reset (already decided):
- One clock, clk; reset reset_n is asynchronous, active-low.
- Reset clears sync chains, counters, sw_clean and sw_changed to 0, regardless of sw_raw.
- Reset asserted mid-count discards the partial count.
- After deassertion, a bit held high needs the full latency below before sw_clean reads 1.

Per bit i, independently:
- Sync chain: sync[0] <= sw_raw[i]; sync[k] <= sync[k-1]. Let s = sync[SYNC_STAGES-1].
- Each rising edge:
  - If s == q: cnt <= 0.
  - Else if cnt == CNT_MAX-1: q <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
- sw_clean[i] = q (registered, no combinational path from sw_raw).

Latency:
- Edge 1 is the rising edge that first samples a new stable level.
- sw_clean changes on edge SYNC_STAGES+CNT_MAX.
- Example: defaults with CNT_MAX=8 gives edge 10.

Glitch rejection:
- A mismatch lasting fewer than CNT_MAX consecutive s-cycles resets cnt to 0 when s returns to q.
- No output change results.
- Bounce during counting restarts the count from 0 on every return to q.

Counter and width:
- Counter saturation is impossible, because cnt clears at CNT_MAX-1.
- cnt is unsigned CNT_W bits.

sw_changed:
- Registered; high for exactly one cycle, coincident with the cycle sw_clean first shows a new value.
- Simultaneous updates of several bits produce a single one-cycle pulse.

Optional Feature:
Macro SW_DEBOUNCE_EDGE_EN.
- Defined: adds outputs sw_rise[WIDTH-1:0] and sw_fall[WIDTH-1:0].
  - Each is a per-bit one-cycle pulse, registered, aligned with the sw_clean transition 0->1 (rise) or 1->0 (fall).
  - Both reset to 0.
  - Intended for a future edge-capture/interrupt PIO.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package sw_debounce_pkg holds:
  - default constants SW_WIDTH=4, SW_SYNC_STAGES=2, SW_CNT_MAX=500000;
  - function computing CNT_W from CNT_MAX;
  - sim constant SW_CNT_MAX_SIM=8.
- One sub-module, sw_debounce_bit:
  - contains one sync chain, counter and q, plus edge pulses when SW_DEBOUNCE_EDGE_EN is defined;
  - instantiated WIDTH times by a generate loop.
- Top-level holds only the sw_changed OR-reduction register.

Test Plan (CNT_MAX=8, SYNC_STAGES=2):
- Reset with sw_raw=4'hF held -> sw_clean=0, sw_changed=0 during reset; sw_clean=4'hF exactly 10 edges after first post-reset edge; sw_changed pulses once.
- sw_raw[0] 0->1 and held -> sw_clean[0]=1 on edge 10; sw_changed high for exactly that one cycle; other bits remain 0.
- sw_raw[1] pulse of 7 cycles high then low -> sw_clean[1] stays 0; sw_changed never asserts.
- sw_raw[2] bounce 1,0,1,1,0 then stable 1 -> sw_clean[2] rises exactly 10 edges after the final 0->1 sample.
- reset_n pulsed low at cycle 5 of a 0->1 count on bit 3 -> sw_clean[3]=0 immediately (async); full 10-edge latency restarts after release.
- With SW_DEBOUNCE_EDGE_EN, sw_raw=4'h5 then 4'hA -> sw_rise=4'h5 one cycle; later sw_rise=4'hA and sw_fall=4'h5 in the same cycle; sw_changed single pulse each time.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package sw_debounce_pkg;

    localparam int SW_WIDTH       = 4;
    localparam int SW_SYNC_STAGES = 2;
    localparam int SW_CNT_MAX     = 500000;   // 10 ms at 50 MHz
    localparam int SW_CNT_MAX_SIM = 8;        // short count for simulation

    // Smallest counter width w with 2**w >= cnt_max.
    function automatic int sw_cnt_w(input int cnt_max);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) < cnt_max)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce_sync_if.sv
// Switch bundle between board pins and the PIO: raw pins in, clean levels out.
// Latency: n/a (wires only).
// Backpressure: none; levels are sampled continuously.
// Optional SW_DEBOUNCE_EDGE_EN adds per-bit sw_rise / sw_fall pulses.
// master: board/stimulus side (drives sw_raw); slave: the debouncer.
interface sw_debounce_sync_if
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic             sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    modport master (output sw_raw, input sw_clean, input sw_changed,
                    input sw_rise, input sw_fall);
    modport slave  (input sw_raw, output sw_clean, output sw_changed,
                    output sw_rise, output sw_fall);
`else
    modport master (output sw_raw, input sw_clean, input sw_changed);
    modport slave  (input sw_raw, output sw_clean, output sw_changed);
`endif
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and accepted level.
// Latency: SYNC_STAGES + CNT_MAX edges from first sample of a new stable level.
// Backpressure: none. Ports: clk, reset_n, sw_raw in; sw_clean, sw_upd
// (combinational "updates on this edge"); sw_rise/sw_fall with SW_DEBOUNCE_EDGE_EN.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SW_SYNC_STAGES,
    parameter int CNT_MAX     = SW_CNT_MAX,
    parameter int CNT_W       = sw_cnt_w(SW_CNT_MAX)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
`ifdef SW_DEBOUNCE_EDGE_EN
    output logic sw_rise,
    output logic sw_fall,
`endif
    output logic sw_upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sw_raw};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s == clean_q) begin
            // Any return to the accepted level throws away the partial count.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign sw_upd   = (clean_d != clean_q);
    assign sw_clean = clean_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = sw_upd & s;
        fall_d = sw_upd & ~s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`endif

endmodule

// File: rtl/sw_debounce_sync.sv
// Debounces WIDTH raw slide switches into clean levels for the PIO in_port.
// Latency: SYNC_STAGES + CNT_MAX clk edges; sw_changed pulses with the update.
// Backpressure: none. Ports: clk, reset_n (async, active-low), sw_if.slave
// (sw_raw in; sw_clean, sw_changed out; sw_rise/sw_fall with SW_DEBOUNCE_EDGE_EN).
module sw_debounce_sync
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH       = SW_WIDTH,
    parameter int SYNC_STAGES = SW_SYNC_STAGES,
    parameter int CNT_MAX     = SW_CNT_MAX,
    parameter int CNT_W       = sw_cnt_w(CNT_MAX)
) (
    input  logic                clk,
    input  logic                reset_n,
    sw_debounce_sync_if.slave   sw_if
);

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] upd_w;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_MAX     (CNT_MAX),
            .CNT_W       (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw   (sw_if.sw_raw[i]),
            .sw_clean (clean_w[i]),
`ifdef SW_DEBOUNCE_EDGE_EN
            .sw_rise  (rise_w[i]),
            .sw_fall  (fall_w[i]),
`endif
            .sw_upd   (upd_w[i])
        );
    end

    // Registered on the same edge as the per-bit levels, so the pulse
    // lines up with the first cycle sw_clean shows the new value.
    logic changed_q, changed_d;

    always_comb begin
        changed_d = |upd_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign sw_if.sw_clean   = clean_w;
    assign sw_if.sw_changed = changed_q;
`ifdef SW_DEBOUNCE_EDGE_EN
    assign sw_if.sw_rise    = rise_w;
    assign sw_if.sw_fall    = fall_w;
`endif

endmodule
